// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and parity
// type constants. The transmitter imports the same package.
package uart_pkg;

  localparam int DATA_W = 8;
  localparam int IDX_W  = $clog2(DATA_W);

  localparam logic PAR_ODD  = 1'b0;
  localparam logic PAR_EVEN = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Parity bit a transmitter appends for the given data and parity type
  function automatic logic parityBit(input logic [DATA_W-1:0] data, input logic typ);
    return (typ == PAR_EVEN) ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// to 1 so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Shift the raw line through two flops clocked in the receiver domain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start(0), 8 data bits LSB first, optional parity, stop(1).
// One sample per bit at the middle of the bit period; results are presented
// at the stop-bit sample point so frames may follow with no idle gap.
// Build option: define UART_RX_SYNC_EN to pass RX_IN through a 2-flop
// synchronizer (adds 2 cycles of latency); otherwise RX_IN is used directly.
module uart_rx
  import uart_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  output logic [DATA_W-1:0] P_DATA,
  output logic              DATA_valid,
  output logic              PAR_ERR,
  output logic              STP_ERR,
  output logic              busy
);

  localparam int                CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0]  MID      = CNT_W'((PRESCALE - 1) / 2);
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);

  rx_state_e         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_parEn;
  logic              r_parTyp;
  logic              r_parBad;
  logic              w_rx;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_async (RX_IN),
    .o_sync  (w_rx)
  );
`else
  assign w_rx = RX_IN;
`endif

  // Frame FSM: bit timing, sampling, error checks and registered result pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_parEn    <= 1'b0;
      r_parTyp   <= 1'b0;
      r_parBad   <= 1'b0;
      P_DATA     <= '0;
      DATA_valid <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      DATA_valid <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx) begin
            r_parEn  <= PAR_EN;
            r_parTyp <= PAR_TYP;
            r_parBad <= 1'b0;
            r_idx    <= '0;
            busy     <= 1'b1;
            if (PRESCALE == 1) begin
              r_state <= DATA;
              r_cnt   <= '0;
            end else begin
              r_state <= START;
              r_cnt   <= CNT_W'(1);
            end
          end
        end
        START: begin
          if (r_cnt == MID && w_rx) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
          end else if (r_cnt == LAST) begin
            r_state <= DATA;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == MID) begin
            r_shift[r_idx] <= w_rx;
          end
          if (r_cnt == LAST) begin
            r_cnt <= '0;
            r_idx <= r_idx + 1'b1;
            if (r_idx == IDX_LAST) begin
              r_state <= r_parEn ? PARITY : STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (r_cnt == MID) begin
            r_parBad <= (w_rx != parityBit(r_shift, r_parTyp));
          end
          if (r_cnt == LAST) begin
            r_state <= STOP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == MID) begin
            P_DATA     <= r_shift;
            DATA_valid <= w_rx & ~r_parBad;
            PAR_ERR    <= r_parBad;
            STP_ERR    <= ~w_rx;
            busy       <= 1'b0;
            r_state    <= IDLE;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: two receivers (PRESCALE=1 and PRESCALE=16) fed by
// frame-level drivers; every result pulse is matched against a queue of
// frames predicted from the frame contents and bit timing.
// Honours UART_RX_SYNC_EN for the expected response latency.
`timescale 1ns/1ps
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic [2:0] flags;
    logic       busy;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx1 = 1'b1, pe1 = 1'b0, pt1 = 1'b0;
  logic       rx16 = 1'b1, pe16 = 1'b0, pt16 = 1'b0;
  logic [7:0] data1, data16;
  logic       valid1, parErr1, stpErr1, busy1;
  logic       valid16, parErr16, stpErr16, busy16;

  int  cyc = 0;
  int  nCompared = 0;
  int  nFailed = 0;
  ev_t obsQ1[$], obsQ16[$], expQ1[$], expQ16[$];

  uart_rx #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .RX_IN(rx1), .PAR_EN(pe1), .PAR_TYP(pt1),
    .P_DATA(data1), .DATA_valid(valid1), .PAR_ERR(parErr1), .STP_ERR(stpErr1), .busy(busy1)
  );

  uart_rx #(.PRESCALE(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .RX_IN(rx16), .PAR_EN(pe16), .PAR_TYP(pt16),
    .P_DATA(data16), .DATA_valid(valid16), .PAR_ERR(parErr16), .STP_ERR(stpErr16), .busy(busy16)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter: value after each rising edge is the index of that edge
  always @(posedge clk) cyc++;

  // Record every cycle on which any result pulse is high, away from the edge
  always @(negedge clk) begin
    if (valid1 | parErr1 | stpErr1)
      obsQ1.push_back('{data1, {valid1, parErr1, stpErr1}, busy1, cyc});
    if (valid16 | parErr16 | stpErr16)
      obsQ16.push_back('{data16, {valid16, parErr16, stpErr16}, busy16, cyc});
  end

  function automatic int presc(input int sel);
    return (sel == 0) ? 1 : 16;
  endfunction

  // Parity bit from the ones count: even type makes the total even, odd makes it odd
  function automatic logic refParity(input logic [7:0] b, input logic evenTyp);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return evenTyp ? logic'(ones % 2) : logic'(1 - (ones % 2));
  endfunction

  function automatic logic getBusy(input int sel);
    return (sel == 0) ? busy1 : busy16;
  endfunction

  function automatic logic [7:0] getData(input int sel);
    return (sel == 0) ? data1 : data16;
  endfunction

  function automatic int obsSize(input int sel);
    return (sel == 0) ? obsQ1.size() : obsQ16.size();
  endfunction

  function automatic int expSize(input int sel);
    return (sel == 0) ? expQ1.size() : expQ16.size();
  endfunction

  task automatic setRx(input int sel, input logic v);
    if (sel == 0) rx1 = v; else rx16 = v;
  endtask

  task automatic setCfg(input int sel, input logic pe, input logic pt);
    if (sel == 0) begin pe1 = pe; pt1 = pt; end
    else begin pe16 = pe; pt16 = pt; end
  endtask

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    assert (got === exp) else begin
      nFailed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one frame on a receiver's line (called at a falling edge); abortAt
  // names the bit index (0=start, 1..8=data) at which reset is pulsed instead
  task automatic applyStimulus(input int sel, input logic [7:0] b, input logic pe,
                               input logic pt, input logic corruptPar,
                               input logic stopBit, input int abortAt);
    int   p = presc(sel);
    int   m = (p - 1) / 2;
    int   nBits = pe ? 11 : 10;
    int   startCyc = cyc + 1;
    logic parBit = refParity(b, pt) ^ corruptPar;
    logic frameBits [0:10];
    logic pErr, sErr;
    frameBits[0] = 1'b0;
    for (int i = 0; i < 8; i++) frameBits[i+1] = b[i];
    frameBits[9] = pe ? parBit : stopBit;
    frameBits[10] = stopBit;
    setCfg(sel, pe, pt);
    for (int k = 0; k < nBits; k++) begin
      if (k == 3) setCfg(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (k == 5) cmp("busy mid-frame", 32'(getBusy(sel)), 32'd1);
      if (k == abortAt) begin
        rst_n = 1'b0;
        #1;
        cmp("busy in reset", 32'(getBusy(sel)), 32'd0);
        cmp("P_DATA in reset", 32'(getData(sel)), 32'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        setRx(sel, 1'b1);
        repeat (2) @(negedge clk);
        return;
      end
      setRx(sel, frameBits[k]);
      if (k == nBits - 1 && !frameBits[k]) begin
        // Bad stop bit released after its sample point so the idle line follows
        repeat (m + 1) @(negedge clk);
        setRx(sel, 1'b1);
        repeat (p - m - 1) @(negedge clk);
      end else begin
        repeat (p) @(negedge clk);
      end
    end
    pErr = pe && (parBit != refParity(b, pt));
    sErr = !stopBit;
    if (sel == 0)
      expQ1.push_back('{b, {!pErr && !sErr, pErr, sErr}, 1'b0,
                        startCyc + (9 + int'(pe)) * p + m + SYNC_LAT});
    else
      expQ16.push_back('{b, {!pErr && !sErr, pErr, sErr}, 1'b0,
                         startCyc + (9 + int'(pe)) * p + m + SYNC_LAT});
  endtask

  // Match the oldest observed pulse against the oldest predicted frame
  task automatic checkOutput(input int sel, input string tag);
    ev_t  o, e;
    int   waited = 0;
    logic got;
    while (obsSize(sel) == 0 && waited < 3000) begin
      @(posedge clk);
      waited++;
    end
    got = (obsSize(sel) != 0);
    cmp({tag, " arrival"}, 32'(got), 32'd1);
    if (!got || expSize(sel) == 0) return;
    if (sel == 0) begin o = obsQ1.pop_front(); e = expQ1.pop_front(); end
    else begin o = obsQ16.pop_front(); e = expQ16.pop_front(); end
    cmp({tag, " P_DATA"}, 32'(o.data), 32'(e.data));
    cmp({tag, " valid/par/stp"}, 32'(o.flags), 32'(e.flags));
    cmp({tag, " busy at pulse"}, 32'(o.busy), 32'(e.busy));
    cmp({tag, " pulse cycle"}, 32'(o.cyc), 32'(e.cyc));
  endtask

  // Bound on total run time
  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Directed and random frame sequence for both receivers
  initial begin
    repeat (3) @(negedge clk);
    cmp("reset P_DATA p1", 32'(data1), 32'h00);
    cmp("reset flags p1", 32'({valid1, parErr1, stpErr1}), 32'd0);
    cmp("reset busy p1", 32'(busy1), 32'd0);
    cmp("reset P_DATA p16", 32'(data16), 32'h00);
    cmp("reset flags p16", 32'({valid16, parErr16, stpErr16}), 32'd0);
    cmp("reset busy p16", 32'(busy16), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int sel = 0; sel < 2; sel++) begin
      $display("[TB] receiver PRESCALE=%0d", presc(sel));
      applyStimulus(sel, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      checkOutput(sel, "A5 odd parity");

      applyStimulus(sel, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, -1);
      checkOutput(sel, "3C parity error");

      applyStimulus(sel, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, -1);
      checkOutput(sel, "3C parity+stop error");

      applyStimulus(sel, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      applyStimulus(sel, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, -1);
      checkOutput(sel, "81 stop error");
      checkOutput(sel, "5A after stop error");

      if (sel == 1) begin
        setRx(1, 1'b0);
        repeat (4) @(negedge clk);
        cmp("glitch busy", 32'(busy16), 32'd1);
        setRx(1, 1'b1);
        repeat (16) @(negedge clk);
        cmp("glitch busy drops", 32'(busy16), 32'd0);
        repeat (32) @(negedge clk);
        cmp("glitch no pulse", 32'(obsQ16.size()), 32'd0);
      end

      applyStimulus(sel, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      applyStimulus(sel, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      applyStimulus(sel, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      checkOutput(sel, "b2b 00");
      checkOutput(sel, "b2b FF");
      checkOutput(sel, "b2b 55");

      applyStimulus(sel, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 5);
      applyStimulus(sel, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      checkOutput(sel, "12 after abort");

      for (int i = 0; i < 12; i++) begin
        applyStimulus(sel, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 9) != 0), -1);
        repeat ($urandom_range(0, 2) * presc(sel)) @(negedge clk);
      end
      for (int i = 0; i < 12; i++) checkOutput(sel, "random frame");
    end

    repeat (64) @(negedge clk);
    cmp("no extra pulses p1", 32'(obsQ1.size()), 32'd0);
    cmp("no extra pulses p16", 32'(obsQ16.size()), 32'd0);
    cmp("no missing frames p1", 32'(expQ1.size()), 32'd0);
    cmp("no missing frames p16", 32'(expQ16.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
